pixel_readout_buffer: RTL and testbench

- Downstream of the pixel sensor and its sequencer: samples the shared 8-bit pixel bus once per read window.
- Tags each sample with pixel index and start-of-frame/end-of-frame markers.
- Queues tagged samples in a small FIFO and presents them on a valid/ready stream to the frame store or serial link.
- Flags overflow and short read windows as sticky errors.

---
 rtl/pixel_readout_pkg.sv | 25 ++
 rtl/pixel_readout_buffer_sync_fifo.sv | 53 +++++
 rtl/pixel_readout_buffer.sv | 131 +++++++++++++
 tb/tb_pixel_readout_buffer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_readout_pkg.sv
// Shared types for the pixel readout buffer: capture states, FIFO entry layout
// and entry width helper.
package pixel_readout_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DEF_IDX_W = 2;

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_WAIT,
    CAP_HOLD
  } cap_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic [DEF_IDX_W-1:0] pix;
    logic                 sof;
    logic                 eof;
  } entry_t;

  function automatic int unsigned entry_width(input int unsigned idx_w);
    return DATA_W + idx_w + 2;
  endfunction

endpackage

// File: rtl/pixel_readout_buffer_sync_fifo.sv
// Register-based synchronous FIFO with occupancy count; head is always
// presented on rd_data (no fall-through).
module sync_fifo #(
  parameter int unsigned W     = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  // Counters carry one extra bit so full and empty stay distinguishable;
  // the low AW bits are the wrapping pointers.
  logic [AW:0]  wr_cnt_q, wr_cnt_d;
  logic [AW:0]  rd_cnt_q, rd_cnt_d;
  logic         do_push, do_pop;

  assign level   = wr_cnt_q - rd_cnt_q;
  assign empty   = (wr_cnt_q == rd_cnt_q);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem_q[rd_cnt_q[AW-1:0]];

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (do_push) wr_cnt_d = wr_cnt_q + 1'b1;
    if (do_pop)  rd_cnt_d = rd_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      if (do_push) mem_q[wr_cnt_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/pixel_readout_buffer.sv
// Samples the pixel bus once per read window, tags it with index/SOF/EOF and
// queues it onto a valid/ready stream; sticky overflow and short-read flags.
module pixel_readout_buffer
  import pixel_readout_pkg::*;
#(
  parameter int unsigned N_PIX      = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned SAMPLE_DLY = 2,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic                      pix_read,
  input  logic [7:0]                pix_data,
  input  logic                      clear_err,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_data,
  output logic [IDX_W-1:0]          out_pix,
  output logic                      out_sof,
  output logic                      out_eof,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic                      short_read
);

  localparam int unsigned EW = entry_width(IDX_W);
  localparam int unsigned CW = $clog2(SAMPLE_DLY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);

  cap_state_e       state_q, state_d;
  logic [CW-1:0]    dly_q, dly_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_next;
  logic             overflow_q, overflow_d;
  logic             short_q, short_d;
  logic             capture, short_set, overflow_set;
  logic             fifo_full, fifo_empty, pop_fire;
  logic [EW-1:0]    push_entry, head_entry;

  assign idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    idx_d     = idx_q;
    capture   = 1'b0;
    short_set = 1'b0;
    if (frame_start) begin
      // A window already open at frame_start is parked in HOLD so it is
      // ignored until pix_read has been seen low, then resumes from IDLE.
      state_d = pix_read ? CAP_HOLD : CAP_IDLE;
      idx_d   = '0;
      dly_d   = '0;
    end else begin
      unique case (state_q)
        CAP_IDLE: begin
          if (pix_read) begin
            state_d = CAP_WAIT;
            dly_d   = CW'(1);
          end
        end
        CAP_WAIT: begin
          if (!pix_read) begin
            short_set = 1'b1;
            idx_d     = idx_next;
            dly_d     = '0;
            state_d   = CAP_IDLE;
          end else if (dly_q == CW'(SAMPLE_DLY)) begin
            capture = 1'b1;
            idx_d   = idx_next;
            state_d = CAP_HOLD;
          end else begin
            dly_d = dly_q + 1'b1;
          end
        end
        CAP_HOLD: begin
          if (!pix_read) state_d = CAP_IDLE;
        end
        default: state_d = CAP_IDLE;
      endcase
    end
  end

  assign pop_fire     = out_valid && out_ready;
  assign overflow_set = capture && fifo_full && !pop_fire;

  always_comb begin
    overflow_d = (overflow_q && !clear_err) || overflow_set;
    short_d    = (short_q && !clear_err) || short_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= CAP_IDLE;
      dly_q      <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      short_q    <= short_d;
    end
  end

  assign push_entry = {pix_data, idx_q, (idx_q == '0), (idx_q == LAST_IDX)};

  sync_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (capture),
    .pop     (out_ready),
    .wr_data (push_entry),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign out_valid = !fifo_empty;
  assign {out_data, out_pix, out_sof, out_eof} = head_entry;
  assign overflow   = overflow_q;
  assign short_read = short_q;

endmodule

// File: tb/tb_pixel_readout_buffer.sv
// Directed self-checking bench for pixel_readout_buffer (N_PIX=4, IDX_W=2,
// SAMPLE_DLY=2, DEPTH=8).
module tb_pixel_readout_buffer;

  logic       clk = 1'b0;
  logic       reset, frame_start, pix_read, clear_err, out_ready;
  logic [7:0] pix_data;
  logic       out_valid, out_sof, out_eof, overflow, short_read;
  logic [7:0] out_data;
  logic [1:0] out_pix;
  logic [3:0] level;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pixel_readout_buffer #(
    .N_PIX      (4),
    .IDX_W      (2),
    .SAMPLE_DLY (2),
    .DEPTH      (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .pix_read    (pix_read),
    .pix_data    (pix_data),
    .clear_err   (clear_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_pix     (out_pix),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .level       (level),
    .overflow    (overflow),
    .short_read  (short_read)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  // 5-cycle read window followed by one low cycle; sample taken at E0+2.
  task automatic window(input logic [7:0] d);
    pix_data = d;
    pix_read = 1'b1;
    step(5);
    pix_read = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(2);
    checks++;
    if ({out_valid, level} !== 5'd0) begin
      errors++;
      $display("FAIL reset_valid_level: got valid=%0b level=%0d expected 0/0", out_valid, level);
    end
    checks++;
    if ({overflow, short_read} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: got ovf=%0b short=%0b expected 0/0", overflow, short_read);
    end
    checks++;
    if ({out_data, out_pix, out_sof, out_eof} !== 12'd0) begin
      errors++;
      $display("FAIL reset_head: got data=%0h pix=%0d sof=%0b eof=%0b expected all 0",
               out_data, out_pix, out_sof, out_eof);
    end
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_frame();
    logic [7:0] d;
    out_ready = 1'b1;
    pulse_frame_start();
    for (int i = 0; i < 4; i++) begin
      d = 8'((i + 1) * 16);
      pix_data = d;
      pix_read = 1'b1;
      step(2);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL frame_latency_e1[%0d]: got valid=%0b expected 0", i, out_valid);
      end
      step(1);
      checks++;
      if ({out_valid, out_data, out_pix, out_sof, out_eof, level} !==
          {1'b1, d, 2'(i), (i == 0), (i == 3), 4'd1}) begin
        errors++;
        $display("FAIL frame_entry[%0d]: got v=%0b d=%0h pix=%0d sof=%0b eof=%0b lvl=%0d expected v=1 d=%0h pix=%0d sof=%0b eof=%0b lvl=1",
                 i, out_valid, out_data, out_pix, out_sof, out_eof, level, d, i, (i == 0), (i == 3));
      end
      step(2);
      checks++;
      if (level !== 4'd0) begin
        errors++;
        $display("FAIL frame_pop[%0d]: got level=%0d expected 0", i, level);
      end
      pix_read = 1'b0;
      step(2);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    pulse_frame_start();
    for (int k = 0; k < 10; k++) begin
      window(8'(8'h50 + k));
      if (k == 7) begin
        checks++;
        if ({level, overflow} !== {4'd8, 1'b0}) begin
          errors++;
          $display("FAIL ovf_fill8: got level=%0d ovf=%0b expected 8/0", level, overflow);
        end
      end else if (k >= 8) begin
        checks++;
        if ({level, overflow} !== {4'd8, 1'b1}) begin
          errors++;
          $display("FAIL ovf_drop[%0d]: got level=%0d ovf=%0b expected 8/1", k, level, overflow);
        end
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({out_valid, out_data, out_pix, out_sof, out_eof} !==
          {1'b1, 8'(8'h50 + k), 2'(k % 4), (k % 4 == 0), (k % 4 == 3)}) begin
        errors++;
        $display("FAIL ovf_drain[%0d]: got v=%0b d=%0h pix=%0d sof=%0b eof=%0b expected d=%0h pix=%0d",
                 k, out_valid, out_data, out_pix, out_sof, out_eof, 8'h50 + k, k % 4);
      end
      step(1);
    end
    checks++;
    if ({level, out_valid, overflow} !== {4'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ovf_drained: got level=%0d v=%0b ovf=%0b expected 0/0/1", level, out_valid, overflow);
    end
    out_ready = 1'b0;
    window(8'hA5);
    checks++;
    if ({out_valid, out_data, out_pix, out_sof, out_eof} !== {1'b1, 8'hA5, 2'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ovf_idx_advance: got v=%0b d=%0h pix=%0d sof=%0b eof=%0b expected 1/a5/2/0/0",
               out_valid, out_data, out_pix, out_sof, out_eof);
    end
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got ovf=%0b expected 0", overflow);
    end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  task automatic test_short_read();
    out_ready = 1'b1;
    pulse_frame_start();
    pix_data = 8'h11;
    pix_read = 1'b1;
    step(1);
    pix_read = 1'b0;
    step(1);
    checks++;
    if ({short_read, level} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL short_set: got short=%0b level=%0d expected 1/0", short_read, level);
    end
    step(1);
    pix_data = 8'h22;
    pix_read = 1'b1;
    step(3);
    checks++;
    if ({out_valid, out_data, out_pix, out_sof, out_eof} !== {1'b1, 8'h22, 2'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL short_next_idx: got v=%0b d=%0h pix=%0d sof=%0b eof=%0b expected 1/22/1/0/0",
               out_valid, out_data, out_pix, out_sof, out_eof);
    end
    step(2);
    pix_read = 1'b0;
    step(1);
    pix_read = 1'b1;
    step(1);
    pix_read = 1'b0;
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
    checks++;
    if (short_read !== 1'b1) begin
      errors++;
      $display("FAIL short_set_wins: got short=%0b expected 1", short_read);
    end
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
    checks++;
    if (short_read !== 1'b0) begin
      errors++;
      $display("FAIL short_clear: got short=%0b expected 0", short_read);
    end
  endtask

  task automatic test_full_pushpop();
    out_ready = 1'b0;
    pulse_frame_start();
    for (int k = 0; k < 8; k++) window(8'(8'hC0 + k));
    checks++;
    if (level !== 4'd8) begin
      errors++;
      $display("FAIL full_fill: got level=%0d expected 8", level);
    end
    pix_data = 8'hC8;
    pix_read = 1'b1;
    step(2);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    checks++;
    if ({level, overflow, out_data, out_pix} !== {4'd8, 1'b0, 8'hC1, 2'd1}) begin
      errors++;
      $display("FAIL full_pushpop: got level=%0d ovf=%0b head=%0h pix=%0d expected 8/0/c1/1",
               level, overflow, out_data, out_pix);
    end
    pix_read = 1'b0;
    step(2);
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if ({out_valid, out_data, out_pix, out_sof, out_eof} !==
          {1'b1, 8'(8'hC0 + k), 2'(k % 4), (k % 4 == 0), (k % 4 == 3)}) begin
        errors++;
        $display("FAIL full_drain[%0d]: got v=%0b d=%0h pix=%0d sof=%0b eof=%0b expected d=%0h pix=%0d",
                 k, out_valid, out_data, out_pix, out_sof, out_eof, 8'hC0 + k, k % 4);
      end
      step(1);
    end
    out_ready = 1'b0;
    checks++;
    if ({level, out_valid} !== {4'd0, 1'b0}) begin
      errors++;
      $display("FAIL full_empty: got level=%0d v=%0b expected 0/0", level, out_valid);
    end
  endtask

  task automatic test_fs_mid();
    out_ready = 1'b1;
    pulse_frame_start();
    window(8'h66);
    pix_data = 8'h77;
    pix_read = 1'b1;
    step(1);
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    step(4);
    checks++;
    if ({level, out_valid} !== {4'd0, 1'b0}) begin
      errors++;
      $display("FAIL fs_mid_nopush: got level=%0d v=%0b expected 0/0", level, out_valid);
    end
    pix_read = 1'b0;
    step(1);
    pix_data = 8'h88;
    pix_read = 1'b1;
    step(3);
    checks++;
    if ({out_valid, out_data, out_pix, out_sof, out_eof} !== {1'b1, 8'h88, 2'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fs_mid_restart: got v=%0b d=%0h pix=%0d sof=%0b eof=%0b expected 1/88/0/1/0",
               out_valid, out_data, out_pix, out_sof, out_eof);
    end
    step(2);
    pix_read = 1'b0;
    step(1);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    pulse_frame_start();
    pix_read = 1'b1;
    step(1);
    pix_read = 1'b0;
    step(2);
    window(8'hA1);
    window(8'hA2);
    window(8'hA3);
    checks++;
    if ({level, out_valid, short_read} !== {4'd3, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL rst_pre: got level=%0d v=%0b short=%0b expected 3/1/1", level, out_valid, short_read);
    end
    pix_read = 1'b1;
    step(1);
    #2;
    reset = 1'b0;
    pix_read = 1'b0;
    #1;
    checks++;
    if ({level, out_valid, overflow, short_read, out_data} !== 16'd0) begin
      errors++;
      $display("FAIL rst_async: got level=%0d v=%0b ovf=%0b short=%0b d=%0h expected all 0",
               level, out_valid, overflow, short_read, out_data);
    end
    step(1);
    reset = 1'b1;
    step(3);
    checks++;
    if (level !== 4'd0) begin
      errors++;
      $display("FAIL rst_no_capture: got level=%0d expected 0", level);
    end
    pix_data = 8'hB4;
    pix_read = 1'b1;
    step(3);
    checks++;
    if ({out_valid, out_data, out_pix, out_sof, level} !== {1'b1, 8'hB4, 2'd0, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL rst_first: got v=%0b d=%0h pix=%0d sof=%0b lvl=%0d expected 1/b4/0/1/1",
               out_valid, out_data, out_pix, out_sof, level);
    end
    pix_read = 1'b0;
    step(2);
  endtask

  initial begin
    reset       = 1'b0;
    frame_start = 1'b0;
    pix_read    = 1'b0;
    pix_data    = 8'h00;
    clear_err   = 1'b0;
    out_ready   = 1'b0;
    test_reset();
    test_frame();
    test_overflow();
    test_short_read();
    test_full_pushpop();
    test_fs_mid();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
